// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller.
// Turns EX/MEM loads and stores into req/ack transactions on a variable-latency
// data memory. It stalls the front of the pipeline while an access is
// outstanding, resolves the beq decision, and holds the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    // EX/MEM pipeline register outputs
    input  logic [31:0] MEM_pc_br,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_ALU_res,
    input  logic [31:0] MEM_rdata2,
    input  logic [4:0]  MEM_wreg,
    input  logic        MEM_memread,
    input  logic        MEM_memwrite,
    input  logic        MEM_branch,
    input  logic        MEM_regwrite,
    input  logic        MEM_memtoreg,
    // data memory handshake
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    // pipeline control
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] pc_br,
    output logic        align_err,
    output logic        bus_err,
    // MEM/WB pipeline register
    output logic [31:0] WB_rdata,
    output logic [31:0] WB_ALU_res,
    output logic [4:0]  WB_wreg,
    output logic        WB_regwrite,
    output logic        WB_memtoreg
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is a power of two.
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   ldata_q, ldata_d;      // load data latched at ack or timeout
    logic          align_err_q, align_err_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   wb_rdata_q, wb_rdata_d;
    logic [31:0]   wb_alu_q, wb_alu_d;
    logic [4:0]    wb_wreg_q, wb_wreg_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic          wb_memtoreg_q, wb_memtoreg_d;

    logic memop;
    logic aligned;
    logic is_load;
    logic misaligned;

    // A set memwrite wins over memread, so "load" means read without write.
    assign memop      = MEM_memread | MEM_memwrite;
    assign aligned    = (MEM_ALU_res[1:0] == 2'b00);
    assign is_load    = MEM_memread & ~MEM_memwrite;
    assign misaligned = memop & ~aligned;

    // Branch resolution: valid in every state; the consumer ignores it while stalled.
    assign pcsrc = MEM_branch & MEM_zero;
    assign pc_br = MEM_pc_br;

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign align_err   = align_err_q;
    assign bus_err     = bus_err_q;
    assign WB_rdata    = wb_rdata_q;
    assign WB_ALU_res  = wb_alu_q;
    assign WB_wreg     = wb_wreg_q;
    assign WB_regwrite = wb_regwrite_q;
    assign WB_memtoreg = wb_memtoreg_q;

    // Next-state, handshake and MEM/WB update logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        ldata_d       = ldata_q;
        align_err_d   = 1'b0;
        bus_err_d     = 1'b0;
        stall         = 1'b0;
        wb_rdata_d    = wb_rdata_q;
        wb_alu_d      = wb_alu_q;
        wb_wreg_d     = wb_wreg_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;

        unique case (state_q)
            IDLE: begin
                if (memop && aligned) begin
                    stall   = 1'b1;
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MEM_memwrite;
                    addr_d  = MEM_ALU_res;
                    wdata_d = MEM_rdata2;
                    cnt_d   = '0;
                end else if (misaligned) begin
                    // Dropped access: no request, instruction flows on without a write.
                    align_err_d = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    if (!we_q) begin
                        ldata_d = dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ldata_d   = ERR_DATA;
                    bus_err_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // No request issued here; the next op is examined in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // MEM/WB: a bubble while stalled, otherwise capture the instruction.
        if (stall) begin
            wb_regwrite_d = 1'b0;
            wb_memtoreg_d = 1'b0;
        end else begin
            wb_alu_d      = MEM_ALU_res;
            wb_wreg_d     = MEM_wreg;
            wb_memtoreg_d = MEM_memtoreg;
            wb_regwrite_d = MEM_regwrite & ~misaligned;
            if (state_q == DONE && is_load) begin
                wb_rdata_d = ldata_q;
            end
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ldata_q       <= '0;
            align_err_q   <= 1'b0;
            bus_err_q     <= 1'b0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
            wb_wreg_q     <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            ldata_q       <= ldata_d;
            align_err_q   <= align_err_d;
            bus_err_q     <= bus_err_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_alu_q      <= wb_alu_d;
            wb_wreg_q     <= wb_wreg_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller sitting on the consumer side of the EX/MEM pipeline register.
- Takes the EX/MEM outputs and issues load/store transactions to a variable-latency data memory over a req/ack handshake.
- Asserts a pipeline stall while an access is outstanding and resolves the branch decision.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
TIMEOUT, 16, max cycles in REQ waiting for dmem_ack before aborting with bus error
ERR_DATA, 32'hDEADBEEF, value returned as load data on timeout

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
MEM_pc_br  in  32  branch target from EX/MEM
MEM_zero  in  1  ALU zero flag from EX/MEM
MEM_ALU_res  in  32  ALU result / memory address from EX/MEM
MEM_rdata2  in  32  store data from EX/MEM
MEM_wreg  in  5  destination register from EX/MEM
MEM_memread  in  1  instruction is a load
MEM_memwrite  in  1  instruction is a store
MEM_branch  in  1  instruction is a beq
MEM_regwrite  in  1  instruction writes the register file
MEM_memtoreg  in  1  write-back selects load data
dmem_req  out  1  memory request, registered, held until ack
dmem_we  out  1  1=write, valid with dmem_req
dmem_addr  out  32  word address, valid with dmem_req
dmem_wdata  out  32  store data, valid with dmem_req
dmem_rdata  in  32  load data, valid when dmem_ack=1
dmem_ack  in  1  one-cycle completion pulse
stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
pcsrc  out  1  combinational: MEM_branch & MEM_zero
pc_br  out  32  combinational passthrough of MEM_pc_br
align_err  out  1  one-cycle pulse, misaligned access dropped
bus_err  out  1  one-cycle pulse, access timed out
WB_rdata  out  32  registered load data
WB_ALU_res  out  32  registered ALU result
WB_wreg  out  5  registered destination
WB_regwrite  out  1  registered write enable
WB_memtoreg  out  1  registered mux select

Behaviour:
- Reset values:
  - State IDLE; timeout counter 0.
  - dmem_req, dmem_we, align_err, bus_err all 0.
  - dmem_addr, dmem_wdata, and all WB_* outputs are 0.
- Reset mid-transaction: the transaction is abandoned. dmem_req is 0 after the reset edge; a late ack is ignored in IDLE.
- Definitions:
  - memop = MEM_memread | MEM_memwrite (if both are set, treat as a write).
  - aligned = (MEM_ALU_res[1:0] == 0).
- FSM states: IDLE, REQ, DONE.
  - IDLE, memop & aligned: stall=1. Next state REQ. Registers dmem_req=1, dmem_we=MEM_memwrite, dmem_addr=MEM_ALU_res, dmem_wdata=MEM_rdata2. Counter is cleared.
  - IDLE, memop & !aligned: stall=0, no request. align_err=1 next cycle. The instruction advances with WB_regwrite forced 0.
  - IDLE, !memop: stall=0. Instruction passes straight to MEM/WB.
  - REQ: stall=1; dmem_req held at 1 with stable addr, wdata and we.
    - On dmem_ack: latch dmem_rdata (loads only), drop dmem_req, go DONE.
    - Else, when counter reaches TIMEOUT-1: latch ERR_DATA, pulse bus_err, drop dmem_req, go DONE.
    - Otherwise: counter increments.
  - DONE: stall=0. MEM/WB captures the instruction with the latched data; next state IDLE.
- Latency: the minimum memory op costs 3 cycles in MEM (2 stall cycles) when ack arrives in the first REQ cycle. Each extra wait cycle adds one stall cycle.
- An ack is accepted only in REQ; an ack arriving in IDLE or DONE is ignored.
- MEM/WB register, updated every edge:
  - stall=1: insert a bubble. WB_regwrite<=0, WB_memtoreg<=0; other WB_* hold.
  - stall=0: WB_ALU_res, WB_wreg and WB_memtoreg load the MEM_* values.
    - WB_regwrite <= MEM_regwrite & !(memop & !aligned).
    - WB_rdata <= the latched load data for a load; hold otherwise.
- pcsrc and pc_br are purely combinational. They are valid in every state; the branch owner must ignore them while stall=1.
- Back-to-back memory ops: after DONE the next op is seen in IDLE. No request is issued in DONE.

Test Plan:
1. ALU op, no memop (MEM_ALU_res=32'h15, wreg=5'd3, regwrite=1) -> stall=0, no dmem_req; next cycle WB_ALU_res=32'h15, WB_wreg=3, WB_regwrite=1.
2. Load at addr 32'h40, ack in the 2nd REQ cycle with rdata=32'hCAFE0001 -> stall high 3 cycles, WB_regwrite=0 during stall; then WB_rdata=32'hCAFE0001, WB_memtoreg=1, WB_regwrite=1; dmem_req=1 exactly 2 cycles.
3. Store at addr 32'h80, wdata=32'h12345678, immediate ack -> dmem_we=1 with that addr/wdata; stall 2 cycles; WB_regwrite=0.
4. Load at 32'h41 (misaligned) -> no dmem_req, stall=0, align_err pulses 1 cycle, WB_regwrite=0.
5. Load at 32'h100, no ack (TIMEOUT=16) -> dmem_req high 16 cycles, bus_err pulse, WB_rdata=32'hDEADBEEF; a later stray ack is ignored.
6. Reset asserted during REQ of a load -> next cycle dmem_req=0, state IDLE, all WB_* 0; beq with MEM_zero=1, MEM_pc_br=32'h200 -> pcsrc=1, pc_br=32'h200 in the same cycle.
